// File: rtl/regbus_wb_master.sv
// Wishbone classic slave to word-only register-bus initiator.
// Byte-lane writes become read-modify-write on the register port.
module regbus_wb_master #(
   parameter int ADR_W    = 8,
   parameter int NUM_REGS = 4
) (
   input  logic             iCLK,
   input  logic             iRSTN,
   input  logic             iWB_CYC,
   input  logic             iWB_STB,
   input  logic             iWB_WE,
   input  logic [ADR_W-1:0] iWB_ADR,
   input  logic [31:0]      iWB_DAT,
   input  logic [3:0]       iWB_SEL,
   output logic [31:0]      oWB_DAT,
   output logic             oWB_ACK,
   output logic             oWB_ERR,
   output logic             oBUSY,
   output logic [ADR_W-1:0] oWADR,
   output logic             oWR,
   output logic [31:0]      oWDAT,
   output logic [ADR_W-1:0] oRADR,
   input  logic [31:0]      iRDAT,
   input  logic             iERR
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_WR,
      S_WCHK,
      S_RESP
   } state_t;

   localparam logic [ADR_W-1:0] NREG = ADR_W'(NUM_REGS);

   state_t           state_q, state_d;
   logic [ADR_W-1:0] adr_q, adr_d;
   logic [31:0]      dat_q, dat_d;
   logic [3:0]       sel_q, sel_d;
   logic             rmw_q, rmw_d;
   logic [31:0]      wbdat_q, wbdat_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic [ADR_W-1:0] wadr_q, wadr_d;
   logic             wr_q, wr_d;
   logic [31:0]      wdat_q, wdat_d;
   logic [ADR_W-1:0] radr_q, radr_d;

   logic             accept;
   logic             req_rmw;
   logic             req_oor;
   logic [31:0]      merged;

   assign accept  = iWB_CYC & iWB_STB;
   assign req_rmw = iWB_WE & (iWB_SEL != 4'hF);
   assign req_oor = (iWB_ADR >= NREG);

   // Unselected lanes keep the register's current contents.
   always_comb begin
      merged = iRDAT;
      for (int b = 0; b < 4; b++) begin
         if (sel_q[b]) begin
            merged[b*8 +: 8] = dat_q[b*8 +: 8];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      sel_d   = sel_q;
      rmw_d   = rmw_q;
      wbdat_d = wbdat_q;
      wadr_d  = wadr_q;
      wdat_d  = wdat_q;
      radr_d  = radr_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      wr_d    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               adr_d = iWB_ADR;
               dat_d = iWB_DAT;
               sel_d = iWB_SEL;
               rmw_d = req_rmw;
               if ((!iWB_WE || req_rmw) && req_oor) begin
                  state_d = S_RESP;
                  err_d   = 1'b1;
               end else if (iWB_WE && !req_rmw) begin
                  state_d = S_WR;
                  wr_d    = 1'b1;
                  wadr_d  = iWB_ADR;
                  wdat_d  = iWB_DAT;
               end else begin
                  state_d = S_RD;
                  radr_d  = iWB_ADR;
               end
            end
         end

         S_RD: begin
            state_d = iWB_CYC ? S_CAP : S_IDLE;
         end

         S_CAP: begin
            if (!iWB_CYC) begin
               state_d = S_IDLE;
            end else if (rmw_q) begin
               state_d = S_WR;
               wr_d    = 1'b1;
               wadr_d  = adr_q;
               wdat_d  = merged;
            end else begin
               state_d = S_RESP;
               ack_d   = 1'b1;
               wbdat_d = iRDAT;
            end
         end

         // The register write has already been issued; an abort here
         // only suppresses the bus response.
         S_WR: begin
            state_d = iWB_CYC ? S_WCHK : S_IDLE;
         end

         S_WCHK: begin
            if (!iWB_CYC) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RESP;
               ack_d   = !iERR;
               err_d   = iERR;
            end
         end

         S_RESP: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge iCLK or negedge iRSTN) begin
      if (!iRSTN) begin
         state_q <= S_IDLE;
         adr_q   <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
         rmw_q   <= 1'b0;
         wbdat_q <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         wadr_q  <= '0;
         wr_q    <= 1'b0;
         wdat_q  <= '0;
         radr_q  <= '0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
         rmw_q   <= rmw_d;
         wbdat_q <= wbdat_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         wadr_q  <= wadr_d;
         wr_q    <= wr_d;
         wdat_q  <= wdat_d;
         radr_q  <= radr_d;
      end
   end

   assign oWB_DAT = wbdat_q;
   assign oWB_ACK = ack_q;
   assign oWB_ERR = err_q;
   assign oBUSY   = busy_q;
   assign oWADR   = wadr_q;
   assign oWR     = wr_q;
   assign oWDAT   = wdat_q;
   assign oRADR   = radr_q;

endmodule

// File: tb/tb_regbus_wb_master.sv
// Bench for regbus_wb_master against a 4-register GPCORE model.
// Responses and register writes are checked through scoreboard queues.
module tb_regbus_wb_master;

   logic        clk;
   logic        rst_n;
   logic        cyc, stb, we;
   logic [7:0]  adr;
   logic [31:0] wdat;
   logic [3:0]  sel;
   logic [31:0] wb_dat;
   logic        wb_ack, wb_err, busy;
   logic [7:0]  r_wadr, r_radr;
   logic        r_wr;
   logic [31:0] r_wdat;
   logic [31:0] rdat_m;
   logic        err_m;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct packed {
      logic        err;
      logic        rd;
      logic [31:0] dat;
   } rsp_t;

   typedef struct packed {
      logic [7:0]  adr;
      logic [31:0] dat;
   } wr_t;

   rsp_t rq[$];
   wr_t  wq[$];

   regbus_wb_master #(
      .ADR_W(8),
      .NUM_REGS(4)
   ) dut (
      .iCLK(clk),
      .iRSTN(rst_n),
      .iWB_CYC(cyc),
      .iWB_STB(stb),
      .iWB_WE(we),
      .iWB_ADR(adr),
      .iWB_DAT(wdat),
      .iWB_SEL(sel),
      .oWB_DAT(wb_dat),
      .oWB_ACK(wb_ack),
      .oWB_ERR(wb_err),
      .oBUSY(busy),
      .oWADR(r_wadr),
      .oWR(r_wr),
      .oWDAT(r_wdat),
      .oRADR(r_radr),
      .iRDAT(rdat_m),
      .iERR(err_m)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // GPCORE register model: registered read data and write-error flag.
   logic [31:0] regs [4];
   always @(posedge clk) begin
      rdat_m <= (r_radr < 8'd4) ? regs[r_radr[1:0]] : 32'h0;
      err_m  <= r_wr && (r_wadr >= 8'd4);
      if (r_wr && r_wadr < 8'd4) begin
         regs[r_wadr[1:0]] <= r_wdat;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (wb_ack || wb_err) begin
         if (rq.size() == 0) begin
            chk("rsp spurious", 1, 0);
         end else begin
            rsp_t e;
            e = rq.pop_front();
            chk("rsp kind", {62'd0, wb_ack, wb_err},
                e.err ? 64'd1 : 64'd2);
            if (e.rd && !e.err) begin
               chk("rsp rdat", wb_dat, e.dat);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (r_wr) begin
         if (wq.size() == 0) begin
            chk("wr spurious", 1, 0);
         end else begin
            wr_t w;
            w = wq.pop_front();
            chk("wr adr", r_wadr, w.adr);
            chk("wr dat", r_wdat, w.dat);
         end
      end
   end

   task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
      wr_t w;
      w.adr = a;
      w.dat = d;
      wq.push_back(w);
   endtask

   task automatic xfer(input logic w, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input int lat, input logic e_err,
                       input logic [31:0] e_dat, input logic e_wr,
                       input logic [31:0] e_wdat, input string tag,
                       input int idle = 1);
      rsp_t r;
      int   k;
      bit   done;
      r.err = e_err;
      r.rd  = !w;
      r.dat = e_dat;
      rq.push_back(r);
      if (e_wr) push_wr(a, e_wdat);
      cyc  = 1'b1;
      stb  = 1'b1;
      we   = w;
      adr  = a;
      wdat = d;
      sel  = s;
      k    = 0;
      done = 0;
      while (!done && k < 20) begin
         @(negedge clk);
         k++;
         if (wb_ack || wb_err) done = 1;
      end
      chk({tag, " done"}, done, 1);
      chk({tag, " lat"}, k, lat);
      chk({tag, " busy"}, busy, 1);
      cyc = 1'b0;
      stb = 1'b0;
      we  = 1'b0;
      repeat (idle) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      cyc   = 1'b0;
      stb   = 1'b0;
      we    = 1'b0;
      adr   = '0;
      wdat  = '0;
      sel   = '0;
      repeat (2) @(negedge clk);
      chk("rst ctl", {wb_ack, wb_err, busy, r_wr, r_wadr, r_radr}, 0);
      chk("rst rdat", wb_dat, 0);
      chk("rst wdat", r_wdat, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Full write and read back
      xfer(1, 8'd1, 32'hFF, 4'hF, 3, 0, 0, 1, 32'hFF, "wr1");
      xfer(0, 8'd1, 0, 4'hF, 3, 0, 32'hFF, 0, 0, "rd1");

      // Byte-lane read-modify-write
      xfer(1, 8'd1, 32'h1234_5678, 4'hF, 3, 0, 0, 1, 32'h1234_5678, "wr1b");
      xfer(1, 8'd1, 32'hAABB_CCDD, 4'b0010, 5, 0, 0, 1,
           32'h1234_CC78, "rmw1");
      xfer(0, 8'd1, 0, 4'hF, 3, 0, 32'h1234_CC78, 0, 0, "rd1b");
      xfer(1, 8'd2, 32'h1122_3344, 4'hF, 3, 0, 0, 1, 32'h1122_3344, "wr2");
      xfer(1, 8'd2, 32'hAABB_CCDD, 4'b1001, 5, 0, 0, 1,
           32'hAA22_33DD, "rmw2");
      xfer(0, 8'd2, 0, 4'hF, 3, 0, 32'hAA22_33DD, 0, 0, "rd2");

      // Out of range
      xfer(1, 8'h10, 32'hDEAD_BEEF, 4'hF, 3, 1, 0, 1, 32'hDEAD_BEEF, "wroor");
      xfer(0, 8'h10, 0, 4'hF, 1, 1, 0, 0, 0, "rdoor");
      xfer(1, 8'h10, 32'h0, 4'b0011, 1, 1, 0, 0, 0, "rmwoor");
      chk("oor radr held", r_radr, 8'd2);

      // RMW aborted in CAP: no write, no response
      cyc = 1'b1; stb = 1'b1; we = 1'b1;
      adr = 8'd1; wdat = 32'h0; sel = 4'b0001;
      repeat (2) @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(negedge clk);
      chk("abort cap busy", busy, 0);
      repeat (3) @(negedge clk);
      xfer(0, 8'd1, 0, 4'hF, 3, 0, 32'h1234_CC78, 0, 0, "rd abort");

      // Full write aborted in WCHK: write lands, no response
      push_wr(8'd2, 32'hCAFE_F00D);
      cyc = 1'b1; stb = 1'b1; we = 1'b1;
      adr = 8'd2; wdat = 32'hCAFE_F00D; sel = 4'hF;
      repeat (2) @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(negedge clk);
      chk("abort wchk busy", busy, 0);
      repeat (3) @(negedge clk);
      xfer(0, 8'd2, 0, 4'hF, 3, 0, 32'hCAFE_F00D, 0, 0, "rd wchk");

      // Reset while the RMW sits in CAP
      cyc = 1'b1; stb = 1'b1; we = 1'b1;
      adr = 8'd1; wdat = 32'hFFFF_FFFF; sel = 4'b0100;
      repeat (2) @(negedge clk);
      chk("pre-rst radr", r_radr, 8'd1);
      rst_n = 1'b0;
      #1;
      chk("mid-rst ctl", {wb_ack, wb_err, busy, r_wr, r_wadr, r_radr}, 0);
      chk("mid-rst rdat", wb_dat, 0);
      chk("mid-rst wdat", r_wdat, 0);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      xfer(0, 8'd1, 0, 4'hF, 3, 0, 32'h1234_CC78, 0, 0, "rd rst");

      // Back-to-back: next request already up on the ACK cycle
      xfer(0, 8'd2, 0, 4'hF, 3, 0, 32'hCAFE_F00D, 0, 0, "b2b rd", 0);
      xfer(1, 8'd3, 32'h55AA_55AA, 4'hF, 4, 0, 0, 1, 32'h55AA_55AA, "b2b wr");
      xfer(0, 8'd3, 0, 4'hF, 3, 0, 32'h55AA_55AA, 0, 0, "b2b chk");

      repeat (3) @(negedge clk);
      chk("rsp drain", rq.size(), 0);
      chk("wr drain", wq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
